// File: rtl/mac_csr_pkg.sv
// Shared definitions for the MAC/PCS CSR access path: FSM states, the
// timeout read pattern and the default watchdog limit.
package mac_csr_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      READ_WAIT,
      DONE
   } csr_state_e;

   localparam logic [31:0] CSR_TIMEOUT_DATA    = 32'hDEADBEEF;
   localparam int          CSR_TIMEOUT_DEFAULT = 1024;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/avalon_csr_master_if.sv
// Avalon-MM bus between the CSR master and the TSE MAC/PCS CSR slave.
interface avalon_csr_master_if #(
   parameter int ADDR_W = 10
) ();

   logic [ADDR_W-1:0] avm_address;
   logic              avm_write;
   logic              avm_read;
   logic [31:0]       avm_writedata;
   logic [31:0]       avm_readdata;
   logic              avm_waitrequest;
   logic              avm_readdatavalid;

   modport master (
      output avm_address, avm_write, avm_read, avm_writedata,
      input  avm_readdata, avm_waitrequest, avm_readdatavalid
   );

   modport slave (
      input  avm_address, avm_write, avm_read, avm_writedata,
      output avm_readdata, avm_waitrequest, avm_readdatavalid
   );

endinterface

// File: rtl/mac_csr_watchdog.sv
// Per-transfer watchdog: counts busy cycles and flags expiry so the
// master can abort a transfer the slave never completes.
module mac_csr_watchdog #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int            CW   = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 2);

   logic [CW-1:0] cnt_q, cnt_d;

   // expire fires in the (TIMEOUT-1)th busy cycle, so DONE lands exactly
   // TIMEOUT cycles after the request was sampled in IDLE
   assign expire = enable && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (enable && (cnt_q != LAST))
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/avalon_csr_master.sv
// Executes single-word CSR read/write requests from the MAC init sequencer
// as Avalon-MM master transfers, with per-transfer timeout and error count.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   IDLE      | waiting for wr_rq / rd_rq (write has priority)
//   WRITE     | avm_write held until waitrequest drops
//   READ      | avm_read held until waitrequest drops
//   READ_WAIT | read accepted, waiting for readdatavalid
//   DONE      | one-cycle completion pulse, requests not sampled
module avalon_csr_master
   import mac_csr_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int BYTE_ADDR = 0,
   parameter int TIMEOUT   = CSR_TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wr_rq,
   input  logic        rd_rq,
   input  logic [31:0] wr_adr,
   input  logic [31:0] rd_adr,
   input  logic [31:0] wr_data,
   output logic        action_done,
   output logic        rd_valid,
   output logic [31:0] rd_data,
   output logic        err,
   output logic [15:0] err_cnt,
   avalon_csr_master_if.master avm
);

   csr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              write_q, write_d;
   logic              read_q, read_d;
   logic              done_q, done_d;
   logic              rd_valid_q, rd_valid_d;
   logic [31:0]       rd_data_q, rd_data_d;
   logic              err_q, err_d;
   logic [15:0]       err_cnt_q, err_cnt_d;
   logic              abort_rd;
   logic              busy;
   logic              expire;
   logic              unused_adr;

   assign unused_adr = ^{wr_adr, rd_adr};

   function automatic logic [ADDR_W-1:0] map_adr(input logic [31:0] a);
      if (BYTE_ADDR != 0)
         return {a[ADDR_W-3:0], 2'b00};
      else
         return a[ADDR_W-1:0];
   endfunction

   assign busy = (state_q == WRITE) || (state_q == READ) || (state_q == READ_WAIT);

   mac_csr_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (!busy),
      .enable  (busy),
      .expire  (expire)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      write_d    = write_q;
      read_d     = read_q;
      done_d     = 1'b0;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      err_d      = 1'b0;
      err_cnt_d  = err_cnt_q;
      abort_rd   = 1'b0;

      case (state_q)
         IDLE: begin
            if (wr_rq) begin
               addr_d  = map_adr(wr_adr);
               wdata_d = wr_data;
               write_d = 1'b1;
               state_d = WRITE;
            end else if (rd_rq) begin
               addr_d  = map_adr(rd_adr);
               read_d  = 1'b1;
               state_d = READ;
            end
         end
         WRITE: begin
            // an accepted write completes cleanly even on the expiry cycle
            if (!avm.avm_waitrequest) begin
               write_d = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end else if (expire) begin
               write_d   = 1'b0;
               done_d    = 1'b1;
               err_d     = 1'b1;
               err_cnt_d = sat_inc16(err_cnt_q);
               state_d   = DONE;
            end
         end
         READ: begin
            if (expire)
               abort_rd = 1'b1;
            else if (!avm.avm_waitrequest) begin
               read_d  = 1'b0;
               state_d = READ_WAIT;
            end
         end
         READ_WAIT: begin
            if (avm.avm_readdatavalid) begin
               rd_data_d  = avm.avm_readdata;
               rd_valid_d = 1'b1;
               done_d     = 1'b1;
               state_d    = DONE;
            end else if (expire)
               abort_rd = 1'b1;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (abort_rd) begin
         read_d     = 1'b0;
         rd_data_d  = CSR_TIMEOUT_DATA;
         rd_valid_d = 1'b1;
         done_d     = 1'b1;
         err_d      = 1'b1;
         err_cnt_d  = sat_inc16(err_cnt_q);
         state_d    = DONE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         write_q    <= 1'b0;
         read_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         err_q      <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         write_q    <= write_d;
         read_q     <= read_d;
         done_q     <= done_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         err_q      <= err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign action_done       = done_q;
   assign rd_valid          = rd_valid_q;
   assign rd_data           = rd_data_q;
   assign err               = err_q;
   assign err_cnt           = err_cnt_q;
   assign avm.avm_address   = addr_q;
   assign avm.avm_write     = write_q;
   assign avm.avm_read      = read_q;
   assign avm.avm_writedata = wdata_q;

endmodule

// File: tb/tb_avalon_csr_master.sv
// Scoreboard bench for avalon_csr_master: directed requests push expected
// bus transfers and completions; monitors pop and compare.
module tb_avalon_csr_master;

   localparam int TO = 16;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic        wr_rq, rd_rq, action_done, rd_valid, err;
   logic [31:0] wr_adr, rd_adr, wr_data, rd_data;
   logic [15:0] err_cnt;

   avalon_csr_master_if #(.ADDR_W(10)) bus ();

   avalon_csr_master #(.ADDR_W(10), .BYTE_ADDR(0), .TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n),
      .wr_rq(wr_rq), .rd_rq(rd_rq), .wr_adr(wr_adr), .rd_adr(rd_adr), .wr_data(wr_data),
      .action_done(action_done), .rd_valid(rd_valid), .rd_data(rd_data),
      .err(err), .err_cnt(err_cnt), .avm(bus)
   );

   logic        b_wr_rq, b_rd_rq, b_action_done, b_rd_valid, b_err;
   logic [31:0] b_wr_adr, b_rd_adr, b_wr_data, b_rd_data;
   logic [15:0] b_err_cnt;

   avalon_csr_master_if #(.ADDR_W(10)) bif ();
   assign bif.avm_waitrequest   = 1'b0;
   assign bif.avm_readdatavalid = 1'b0;
   assign bif.avm_readdata      = 32'h0;

   avalon_csr_master #(.ADDR_W(10), .BYTE_ADDR(1), .TIMEOUT(TO)) dut_byte (
      .clk(clk), .reset_n(reset_n),
      .wr_rq(b_wr_rq), .rd_rq(b_rd_rq), .wr_adr(b_wr_adr), .rd_adr(b_rd_adr), .wr_data(b_wr_data),
      .action_done(b_action_done), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
      .err(b_err), .err_cnt(b_err_cnt), .avm(bif)
   );

   typedef struct {
      bit          rdv;
      logic [31:0] data;
      bit          err;
      logic [15:0] cnt;
      int          cyc;
   } done_exp_t;

   typedef struct {
      bit          wr;
      logic [9:0]  adr;
      logic [31:0] wd;
   } bus_exp_t;

   done_exp_t dq[$];
   bus_exp_t  bq[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // slave model configuration, written by the stimulus on negedges
   int          wait_left = 0;
   int          rdv_extra = 0;
   int          rdv_cnt   = 0;
   logic [31:0] rdata_cfg = '0;
   bit          stuck     = 1'b0;
   bit          stray     = 1'b0;

   initial begin
      bus.avm_waitrequest   = 1'b0;
      bus.avm_readdatavalid = 1'b0;
      bus.avm_readdata      = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.avm_readdatavalid = 1'b0;
         if (stray) begin
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata      = 32'h1357_9BDF;
            stray                 = 1'b0;
         end
         if (rdv_cnt > 0) begin
            rdv_cnt--;
            if (rdv_cnt == 0) begin
               bus.avm_readdatavalid = 1'b1;
               bus.avm_readdata      = rdata_cfg;
            end
         end
         if (!reset_n) begin
            rdv_cnt             = 0;
            bus.avm_waitrequest = 1'b0;
         end else if (bus.avm_write || bus.avm_read) begin
            if (stuck || wait_left > 0) begin
               bus.avm_waitrequest = 1'b1;
               if (!stuck) wait_left--;
            end else begin
               bus.avm_waitrequest = 1'b0;
               if (bus.avm_read) rdv_cnt = 1 + rdv_extra;
            end
         end else begin
            bus.avm_waitrequest = 1'b0;
         end
      end
   end

   // monitor: accepted bus transfers and completion pulses
   always @(negedge clk) begin
      if (reset_n) begin
         if ((bus.avm_write || bus.avm_read) && !bus.avm_waitrequest) begin
            if (bq.size() == 0) begin
               checks++; errors++;
               $display("FAIL bus_unexpected actual=transfer required=none (cycle %0d)", cyc);
            end else begin
               bus_exp_t b;
               b = bq.pop_front();
               chk("bus_is_write", {31'd0, bus.avm_write}, {31'd0, b.wr});
               chk("bus_address", {22'd0, bus.avm_address}, {22'd0, b.adr});
               if (b.wr) chk("bus_writedata", bus.avm_writedata, b.wd);
            end
         end
         if (action_done) begin
            if (dq.size() == 0) begin
               checks++; errors++;
               $display("FAIL done_unexpected actual=action_done required=none (cycle %0d)", cyc);
            end else begin
               done_exp_t e;
               e = dq.pop_front();
               chk("done_rd_valid", {31'd0, rd_valid}, {31'd0, e.rdv});
               chk("done_rd_data", rd_data, e.data);
               chk("done_err", {31'd0, err}, {31'd0, e.err});
               chk("done_err_cnt", {16'd0, err_cnt}, {16'd0, e.cnt});
               chk("done_cycle", cyc, e.cyc);
            end
         end else if (rd_valid || err) begin
            checks++; errors++;
            $display("FAIL pulse_without_done actual=rd_valid:%b err:%b required=0 (cycle %0d)",
                     rd_valid, err, cyc);
         end
      end
   end

   task automatic run_txn(
      input bit dw, input bit dr,
      input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra,
      input int ws, input int rdx, input logic [31:0] rdat, input bit stk,
      input bit exp_bus, input bit exp_bw, input logic [9:0] exp_ba, input logic [31:0] exp_bd,
      input bit e_rdv, input logic [31:0] e_data, input bit e_err, input logic [15:0] e_cnt,
      input int lat);
      bit seen;
      @(negedge clk);
      wait_left = ws;
      rdv_extra = rdx;
      rdata_cfg = rdat;
      stuck     = stk;
      if (exp_bus) bq.push_back('{exp_bw, exp_ba, exp_bd});
      @(posedge clk);
      #1;
      wr_rq   = dw;
      rd_rq   = dr;
      wr_adr  = wa;
      wr_data = wd;
      rd_adr  = ra;
      dq.push_back('{e_rdv, e_data, e_err, e_cnt, cyc + lat});
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (action_done) seen = 1'b1;
      end
      wr_rq = 1'b0;
      rd_rq = 1'b0;
      stuck = 1'b0;
      if (!seen) begin
         checks++; errors++;
         $display("FAIL txn_no_done actual=none required=action_done within 200 cycles");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL sim_time_limit actual=running required=finished");
      $fatal(1, "time limit");
   end

   initial begin
      int  c0;
      int  b_done_cyc;
      bit  b_seen_wr;
      reset_n  = 1'b0;
      wr_rq    = 1'b0; rd_rq = 1'b0; wr_adr = '0; rd_adr = '0; wr_data = '0;
      b_wr_rq  = 1'b0; b_rd_rq = 1'b0; b_wr_adr = '0; b_rd_adr = '0; b_wr_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_action_done", {31'd0, action_done}, 32'd0);
      chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
      chk("rst_strobes", {30'd0, bus.avm_write, bus.avm_read}, 32'd0);
      chk("rst_address", {22'd0, bus.avm_address}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // zero-wait write
      run_txn(1, 0, 32'h08, 32'h0000_0003, 32'h0, 0, 0, 32'h0, 0,
              1, 1, 10'h08, 32'h0000_0003, 0, 32'h0, 0, 16'd0, 2);
      // read: 3 waitrequest cycles, readdatavalid 2 cycles late
      run_txn(0, 1, 32'h0, 32'h0, 32'h91, 3, 2, 32'h0000_0901, 0,
              1, 0, 10'h91, 32'h0, 1, 32'h0000_0901, 0, 16'd0, 8);
      // waitrequest stuck: timeout after TO cycles
      run_txn(0, 1, 32'h0, 32'h0, 32'h55, 0, 0, 32'h0, 1,
              0, 0, 10'h0, 32'h0, 1, 32'hDEADBEEF, 1, 16'd1, TO);
      @(negedge clk);
      stray = 1'b1;
      repeat (4) @(negedge clk);
      chk("stray_rdv_rd_data", rd_data, 32'hDEADBEEF);

      // both requests: write wins, read served on re-assertion
      run_txn(1, 1, 32'h20, 32'hA5A5_0001, 32'h33, 1, 0, 32'h0, 0,
              1, 1, 10'h20, 32'hA5A5_0001, 0, 32'hDEADBEEF, 0, 16'd1, 3);
      run_txn(0, 1, 32'h0, 32'h0, 32'h33, 0, 0, 32'h0000_1234, 0,
              1, 0, 10'h33, 32'h0, 1, 32'h0000_1234, 0, 16'd1, 3);

      // async reset mid-read
      @(negedge clk);
      stuck = 1'b1;
      @(posedge clk);
      #1;
      rd_rq  = 1'b1;
      rd_adr = 32'h44;
      repeat (4) @(posedge clk);
      #2;
      chk("pre_reset_avm_read", {31'd0, bus.avm_read}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("reset_avm_read", {31'd0, bus.avm_read}, 32'd0);
      chk("reset_action_done", {31'd0, action_done}, 32'd0);
      chk("reset_err_cnt", {16'd0, err_cnt}, 32'd0);
      rd_rq = 1'b0;
      stuck = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      run_txn(0, 1, 32'h0, 32'h0, 32'h91, 0, 1, 32'hCAFE_0002, 0,
              1, 0, 10'h91, 32'h0, 1, 32'hCAFE_0002, 0, 16'd0, 4);

      // byte-addressed instance
      @(posedge clk);
      #1;
      b_wr_rq   = 1'b1;
      b_wr_adr  = 32'h94;
      b_wr_data = 32'h0000_0077;
      c0 = cyc;
      b_done_cyc = -1;
      b_seen_wr  = 1'b0;
      for (int i = 0; i < 20 && b_done_cyc < 0; i++) begin
         @(negedge clk);
         if (bif.avm_write) begin
            b_seen_wr = 1'b1;
            chk("byte_address", {22'd0, bif.avm_address}, 32'h250);
            chk("byte_writedata", bif.avm_writedata, 32'h0000_0077);
         end
         if (b_action_done) begin
            b_done_cyc = cyc;
            chk("byte_rd_valid", {31'd0, b_rd_valid}, 32'd0);
            chk("byte_err", {31'd0, b_err}, 32'd0);
            chk("byte_err_cnt", {16'd0, b_err_cnt}, 32'd0);
            chk("byte_rd_data", b_rd_data, 32'd0);
            b_wr_rq = 1'b0;
         end
      end
      b_wr_rq = 1'b0;
      chk("byte_write_seen", {31'd0, b_seen_wr}, 32'd1);
      chk("byte_done_latency", b_done_cyc - c0, 32'd2);

      repeat (4) @(negedge clk);
      chk("done_queue_empty", dq.size(), 32'd0);
      chk("bus_queue_empty", bq.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/avalon_csr_master.md
# avalon_csr_master

Responder side of the MAC/PCS register-access handshake: accepts single word read/write requests from an init sequencer (wr_rq/rd_rq held until action_done), executes each as one Avalon-MM master transfer toward the TSE MAC/PCS CSR slave, and returns completion, read data and a timeout error. Sits between the MAC init sequencer and the MAC control port; one transfer in flight at a time.

## Interface
- ADDR_W, 10: Avalon address width.
- BYTE_ADDR, 0: 1 = avm_address is the request word address shifted left by 2; 0 = word address passed through.
- TIMEOUT, 1024: cycles allowed per transfer before abort; must be ≥ 2.
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- wr_rq  in  1  write request; level, held by requester until action_done.
- rd_rq  in  1  read request; level, held until action_done.
- wr_adr  in  32  write word address; low ADDR_W (or ADDR_W-2 when BYTE_ADDR) bits used.
- rd_adr  in  32  read word address, same rule.
- wr_data  in  32  write data.
- action_done  out  1  one-cycle completion pulse.
- rd_valid  out  1  one-cycle pulse, coincident with action_done on read completion.
- rd_data  out  32  last read result; held until next read completes.
- err  out  1  one-cycle pulse with action_done when the transfer timed out.
- err_cnt  out  16  saturating count of timeouts.
- avm_address  out  ADDR_W  Avalon address.
- avm_write  out  1  Avalon write strobe.
- avm_read  out  1  Avalon read strobe.
- avm_writedata  out  32  Avalon write data.
- avm_readdata  in  32  Avalon read data.
- avm_waitrequest  in  1  slave stall.
- avm_readdatavalid  in  1  read data valid.

## Operation
- Reset: all outputs 0, state IDLE, watchdog cleared.
- States: IDLE, WRITE, READ, READ_WAIT, DONE.
- IDLE: wr_rq=1 → latch wr_adr/wr_data, avm_write=1, go WRITE; else rd_rq=1 → latch rd_adr, avm_read=1, go READ. Both high: write wins, read served on later request.
- WRITE/READ: strobe, address, data held constant while avm_waitrequest=1. First cycle with waitrequest=0: strobe drops at next edge; WRITE → DONE, READ → READ_WAIT.
- READ_WAIT: avm_readdatavalid=1 → rd_data ← avm_readdata, go DONE with rd_valid.
- DONE: action_done=1 (and rd_valid for reads, err on timeout) for exactly one cycle, then IDLE. Requests are not sampled in DONE, giving the requester its one cycle to drop rq.
- Watchdog: counts cycles in WRITE/READ/READ_WAIT, cleared on entering IDLE. Reaching TIMEOUT-1: strobes drop, go DONE with err=1; reads load rd_data=32'hDEADBEEF and pulse rd_valid. err_cnt increments, saturates at 16'hFFFF.
- avm_readdatavalid outside READ_WAIT (late data after timeout) ignored.
- Request inputs changing while busy are ignored; only IDLE-captured values are used.
- reset_n low mid-transfer: strobes drop immediately (async), no action_done issued.

## Timing
- Request seen high at edge t → strobe asserted from t+1.
- Write, zero wait states: strobe at t+1, action_done at t+2.
- Read, zero wait, readdatavalid one cycle after accepted read: strobe t+1, readdatavalid t+2, action_done/rd_valid/rd_data updated at t+3.
- Each waitrequest cycle or readdatavalid delay adds one cycle.
- All outputs registered; no combinational path from avm_* inputs to requester outputs.
- Back-to-back: next request earliest accepted in the IDLE cycle after DONE.

## Structure
- Shared package mac_csr_pkg: state enum, CSR_TIMEOUT_DATA = 32'hDEADBEEF, default TIMEOUT value; also used by the init sequencer and benches.
- One sub-module: mac_csr_watchdog (clear, enable, expire; TIMEOUT parameter, $clog2 width counter).

## Test plan
- Write wr_adr=0x08, wr_data=0x0000_0003, waitrequest low → avm_write one cycle, address 0x08, action_done two cycles after wr_rq, no rd_valid.
- Read rd_adr=0x91 with 3 waitrequest cycles, readdatavalid 2 cycles later, data 0x0000_0901 → rd_data=0x0000_0901, rd_valid and action_done same cycle, latency 3+2+3 cycles.
- BYTE_ADDR=1, write to word 0x94 → avm_address=0x250.
- waitrequest stuck high, TIMEOUT=16, read → action_done+err+rd_valid at 16 cycles, rd_data=0xDEADBEEF, err_cnt=1; stray readdatavalid afterwards ignored.
- wr_rq and rd_rq both high → write executes first; read follows after requester re-asserts.
- reset_n asserted while avm_read high with waitrequest → avm_read, action_done, err_cnt all 0 immediately; fresh request after release completes normally.
